fpu_issue_ctrl: RTL and testbench
=================================

# fpu_issue_ctrl

Request/response sequencer that sits directly upstream and downstream of the private FPU wrapper. It buffers incoming FP operation requests in a small FIFO and issues them to the FPU with `Enable` pulses. It tracks in-flight operations against a fixed FPU latency, captures each result and its flags into a response register with valid/ready backpressure, and asserts the FPU `Stall` input when the response cannot be accepted. It also keeps a sticky accumulator of the exception flags.

## Interface
- `FPU_LATENCY`, default 2: unstalled cycles from the issue edge to the result appearing on `FpuResult_DI`; must be ≥1.
- `DEPTH`, default 2: request FIFO entries; must be ≥2.
- `TAG_W`, default 4: width of the request tag carried through to the response.
- `Clk_CI`  in  1  clock; one clock domain.
- `Rst_RI`  in  1  reset, asynchronous, active-high.
- `ReqValid_SI` in 1; `ReqReady_SO` out 1: request handshake.
- `ReqOpA_DI`, `ReqOpB_DI` in 32: operands.
- `ReqRM_SI` in 2: rounding mode. `ReqOP_SI` in 4: opcode. `ReqTag_DI` in `TAG_W`: tag.
- `FpuEnable_SO` out 1: issue strobe. `FpuStall_SO` out 1: freezes the FPU pipeline.
- `FpuOpA_DO`, `FpuOpB_DO` out 32; `FpuRM_SO` out 2; `FpuOP_SO` out 4: FIFO head fields.
- `FpuResult_DI` in 32: FPU result.
- `FpuFlags_SI` in 9: FPU flags, `{0, Inf, IV, IX, Zero, 0, 0, UF, OF}`.
- `RespValid_SO` out 1; `RespReady_SI` in 1: response handshake.
- `RespResult_DO` out 32; `RespFlags_SO` out 9; `RespTag_DO` out `TAG_W`: response payload.
- `FlagsAcc_SO` out 4: sticky `{IV, OF, UF, IX}`.
- `FlagsClr_SI` in 1: clears `FlagsAcc_SO`.

## Operation
- **FIFO**
  - Holds `{OpA, OpB, RM, OP, Tag}`; `ReqReady_SO = !full` (combinational).
  - Push on `ReqValid_SI & ReqReady_SO`.
  - No bypass: an entry pushed into an empty FIFO issues no earlier than the next cycle.
  - Pointers wrap from `DEPTH-1` to 0; an occupancy counter runs 0..`DEPTH`.
- **FPU drive**
  - `FpuOp*`/`FpuRM_SO`/`FpuOP_SO` always show the FIFO head (all-zero after reset).
  - `FpuEnable_SO = !empty & !FpuStall_SO`; a pop occurs on every cycle `FpuEnable_SO` is high (issue).
- **In-flight tracker**
  - Shift register of `FPU_LATENCY` stages `{valid, tag}`.
  - When `!FpuStall_SO`: stage0 ← `{issue, headTag}`, stage i ← stage i-1.
  - When `FpuStall_SO`: all stages hold.
  - `FpuResult_DI`/`FpuFlags_SI` are valid for the op in the last stage while that stage is valid.
- **Backpressure**
  - `FpuStall_SO = lastValid & RespValid_SO & !RespReady_SI` (combinational).
- **Response register**
  - Loads `{FpuResult_DI, FpuFlags_SI, lastTag}` and sets `RespValid_SO` on `lastValid & !FpuStall_SO`.
  - Otherwise clears `RespValid_SO` on `RespReady_SI`.
  - Payload holds while `RespValid_SO & !RespReady_SI`.
  - Sustains one response per cycle.
- **Flag accumulator**
  - On each response load, `FlagsAcc_SO |= {flags[6], flags[0], flags[1], flags[5]}`.
  - `FlagsClr_SI` zeroes the accumulator first. If a load happens in the same cycle, the result is exactly the new flags.
- **Ordering**: responses leave strictly in request order; no reordering, no drops.

## Timing
- Reset (asynchronous, effective immediately):
  - FIFO emptied, occupancy 0, tracker valids 0.
  - `RespValid_SO`=0; `RespResult_DO`, `RespFlags_SO`, `RespTag_DO`=0.
  - `FlagsAcc_SO`=0, `FpuEnable_SO`=0, `FpuStall_SO`=0, `ReqReady_SO`=1.
  - In-flight ops are discarded, including reset mid-operation; no response is produced for them.
- Latency: request accepted at edge E0 → issue at E1 → `RespValid_SO` high after edge E(1+`FPU_LATENCY`), i.e. 3 cycles at default. Each stall cycle adds one.
- Throughput: one request per cycle with `RespReady_SI` held high, provided the FIFO never fills.
- Full FIFO: `ReqReady_SO`=0; it rises the cycle after a pop.
- Simultaneous events: a push and a pop in the same cycle leave occupancy unchanged.
- Stall with an empty tracker (`lastValid`=0): `FpuStall_SO` stays 0 even if the response is stuck, so issue continues until the last stage fills.

## Test plan
- **Single op**: push A=`0x3F800000`, B=`0x40000000`, OP=0, tag=3. The behavioural FPU model has latency 2 and returns `0x40400000`, flags `0x020`. Expect `RespValid_SO` 3 cycles after accept, result `0x40400000`, tag 3, `FlagsAcc_SO`=`0001`.
- **Back-to-back**: 8 pushes, tags 0..7, `RespReady_SI`=1. Expect 8 consecutive response cycles, tags 0..7 in order, `ReqReady_SO` never low.
- **Backpressure**: 4 ops with `RespReady_SI`=0. Expect `FpuStall_SO`=1 once the last stage is valid, `FpuEnable_SO`=0 while stalled, and `ReqReady_SO`=0 when the FIFO is full. Release ready: 4 responses in order, none lost or duplicated.
- **Flags**:
  - op1 flags `0x040` (IV), op2 flags `0x001` (OF) → `FlagsAcc_SO`=`1100`.
  - Pulse `FlagsClr_SI` in the same cycle op3 (flags `0x002`) loads → `FlagsAcc_SO`=`0010`.
- **Reset mid-flight**: assert `Rst_RI` with 2 ops in the FIFO and 2 in flight. Expect all outputs at reset values immediately. After release: no stale responses, and a fresh op completes normally.

Source files
------------

// File: rtl/fpu_issue_ctrl.sv
// Issue/response sequencer around a fixed-latency FPU.
// Buffers requests, issues them with Enable pulses, tracks in-flight tags,
// registers results with valid/ready backpressure and keeps sticky exception flags.
module fpu_issue_ctrl #(
  parameter int unsigned FPU_LATENCY = 2,
  parameter int unsigned DEPTH       = 2,
  parameter int unsigned TAG_W       = 4
) (
  input  logic             Clk_CI,
  input  logic             Rst_RI,
  input  logic             ReqValid_SI,
  output logic             ReqReady_SO,
  input  logic [31:0]      ReqOpA_DI,
  input  logic [31:0]      ReqOpB_DI,
  input  logic [1:0]       ReqRM_SI,
  input  logic [3:0]       ReqOP_SI,
  input  logic [TAG_W-1:0] ReqTag_DI,
  output logic             FpuEnable_SO,
  output logic             FpuStall_SO,
  output logic [31:0]      FpuOpA_DO,
  output logic [31:0]      FpuOpB_DO,
  output logic [1:0]       FpuRM_SO,
  output logic [3:0]       FpuOP_SO,
  input  logic [31:0]      FpuResult_DI,
  input  logic [8:0]       FpuFlags_SI,
  output logic             RespValid_SO,
  input  logic             RespReady_SI,
  output logic [31:0]      RespResult_DO,
  output logic [8:0]       RespFlags_SO,
  output logic [TAG_W-1:0] RespTag_DO,
  output logic [3:0]       FlagsAcc_SO,
  input  logic             FlagsClr_SI
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [31:0]      op_a;
    logic [31:0]      op_b;
    logic [1:0]       rm;
    logic [3:0]       op;
    logic [TAG_W-1:0] tag;
  } req_t;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
  } stage_t;

  req_t             fifo_mem [DEPTH];
  req_t             req_in;
  req_t             head;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;

  stage_t [FPU_LATENCY-1:0] trk;
  stage_t [FPU_LATENCY-1:0] trk_shift;
  stage_t                   stage_new;
  stage_t                   last;

  logic       stall;
  logic       load;
  logic [3:0] flags_new;

  // Request FIFO status and handshake
  assign req_in      = '{op_a: ReqOpA_DI, op_b: ReqOpB_DI, rm: ReqRM_SI,
                         op: ReqOP_SI, tag: ReqTag_DI};
  assign full        = (count == CNT_W'(DEPTH));
  assign empty       = (count == '0);
  assign ReqReady_SO = ~full;
  assign push        = ReqValid_SI & ~full;
  assign head        = fifo_mem[rd_ptr];

  // FPU drive: head fields shown continuously, issue whenever not empty and not frozen
  assign pop          = ~empty & ~stall;
  assign FpuEnable_SO = pop;
  assign FpuStall_SO  = stall;
  assign FpuOpA_DO    = head.op_a;
  assign FpuOpB_DO    = head.op_b;
  assign FpuRM_SO     = head.rm;
  assign FpuOP_SO     = head.op;

  // Backpressure only matters once a result is actually waiting in the last stage
  assign last  = trk[FPU_LATENCY-1];
  assign stall = last.valid & RespValid_SO & ~RespReady_SI;
  assign load  = last.valid & ~stall;

  assign stage_new = '{valid: pop, tag: head.tag};

  // Tracker shift path; a single-stage tracker has nothing to shift through
  if (FPU_LATENCY == 1) begin : g_lat1
    assign trk_shift = stage_new;
  end else begin : g_latn
    assign trk_shift = {trk[FPU_LATENCY-2:0], stage_new};
  end

  assign flags_new = {FpuFlags_SI[6], FpuFlags_SI[0], FpuFlags_SI[1], FpuFlags_SI[5]};

  // FIFO storage, wrapping pointers and occupancy counter
  always_ff @(posedge Clk_CI or posedge Rst_RI) begin
    if (Rst_RI) begin
      fifo_mem <= '{default: '0};
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= req_in;
        wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // In-flight tracker: advances in lockstep with the FPU pipeline, frozen by stall
  always_ff @(posedge Clk_CI or posedge Rst_RI) begin
    if (Rst_RI) begin
      trk <= '0;
    end else if (!stall) begin
      trk <= trk_shift;
    end
  end

  // Response register: capture on completion, drop on consumer ready
  always_ff @(posedge Clk_CI or posedge Rst_RI) begin
    if (Rst_RI) begin
      RespValid_SO  <= 1'b0;
      RespResult_DO <= '0;
      RespFlags_SO  <= '0;
      RespTag_DO    <= '0;
    end else if (load) begin
      RespValid_SO  <= 1'b1;
      RespResult_DO <= FpuResult_DI;
      RespFlags_SO  <= FpuFlags_SI;
      RespTag_DO    <= last.tag;
    end else if (RespReady_SI) begin
      RespValid_SO  <= 1'b0;
    end
  end

  // Sticky flags; a clear coinciding with a load keeps only the new flags
  always_ff @(posedge Clk_CI or posedge Rst_RI) begin
    if (Rst_RI) begin
      FlagsAcc_SO <= '0;
    end else if (FlagsClr_SI) begin
      FlagsAcc_SO <= load ? flags_new : '0;
    end else if (load) begin
      FlagsAcc_SO <= FlagsAcc_SO | flags_new;
    end
  end

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Self-checking bench for fpu_issue_ctrl: behavioural FPU, request scoreboard,
// directed vector table, multi-cycle corner sequences and randomized traffic.
module tb_fpu_issue_ctrl;

  localparam int unsigned LAT   = 2;
  localparam int unsigned DEPTH = 2;
  localparam int unsigned TAG_W = 4;

  logic             Clk_CI = 1'b0;
  logic             Rst_RI = 1'b0;
  logic             ReqValid_SI = 1'b0;
  logic             ReqReady_SO;
  logic [31:0]      ReqOpA_DI = '0;
  logic [31:0]      ReqOpB_DI = '0;
  logic [1:0]       ReqRM_SI = '0;
  logic [3:0]       ReqOP_SI = '0;
  logic [TAG_W-1:0] ReqTag_DI = '0;
  logic             FpuEnable_SO;
  logic             FpuStall_SO;
  logic [31:0]      FpuOpA_DO;
  logic [31:0]      FpuOpB_DO;
  logic [1:0]       FpuRM_SO;
  logic [3:0]       FpuOP_SO;
  logic [31:0]      FpuResult_DI;
  logic [8:0]       FpuFlags_SI;
  logic             RespValid_SO;
  logic             RespReady_SI = 1'b1;
  logic [31:0]      RespResult_DO;
  logic [8:0]       RespFlags_SO;
  logic [TAG_W-1:0] RespTag_DO;
  logic [3:0]       FlagsAcc_SO;
  logic             FlagsClr_SI = 1'b0;

  always #5 Clk_CI = ~Clk_CI;

  fpu_issue_ctrl #(.FPU_LATENCY(LAT), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .Clk_CI(Clk_CI), .Rst_RI(Rst_RI),
    .ReqValid_SI(ReqValid_SI), .ReqReady_SO(ReqReady_SO),
    .ReqOpA_DI(ReqOpA_DI), .ReqOpB_DI(ReqOpB_DI), .ReqRM_SI(ReqRM_SI),
    .ReqOP_SI(ReqOP_SI), .ReqTag_DI(ReqTag_DI),
    .FpuEnable_SO(FpuEnable_SO), .FpuStall_SO(FpuStall_SO),
    .FpuOpA_DO(FpuOpA_DO), .FpuOpB_DO(FpuOpB_DO), .FpuRM_SO(FpuRM_SO), .FpuOP_SO(FpuOP_SO),
    .FpuResult_DI(FpuResult_DI), .FpuFlags_SI(FpuFlags_SI),
    .RespValid_SO(RespValid_SO), .RespReady_SI(RespReady_SI),
    .RespResult_DO(RespResult_DO), .RespFlags_SO(RespFlags_SO), .RespTag_DO(RespTag_DO),
    .FlagsAcc_SO(FlagsAcc_SO), .FlagsClr_SI(FlagsClr_SI)
  );

  typedef struct {
    logic [31:0]      a;
    logic [31:0]      b;
    logic [1:0]       rm;
    logic [3:0]       op;
    logic [TAG_W-1:0] tag;
    int               acc_cyc;
  } op_t;

  typedef struct {
    logic [31:0]      a;
    logic [31:0]      b;
    logic [3:0]       op;
    logic [TAG_W-1:0] tag;
    bit               clr_before;
    logic [31:0]      res;
    logic [8:0]       fl;
    logic [3:0]       acc;
  } vec_t;

  op_t        pend[$];
  op_t        expq[$];
  int         resp_log[$];
  int         lat_log[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  int         n_resp   = 0;
  int         cyc      = 0;
  bit         ready_rand = 0;
  bit         gap_mode   = 0;
  logic       ready_fixed = 1'b1;
  logic       clr_req = 1'b0;
  logic [3:0] acc_model = '0;

  // Behavioural FPU arithmetic: {result, flags}
  function automatic logic [40:0] fpu_calc(input logic [31:0] a, input logic [31:0] b,
                                           input logic [1:0] rm, input logic [3:0] op);
    if (a == 32'h3F80_0000 && b == 32'h4000_0000 && op == 4'h0 && rm == 2'b00)
      return {32'h4040_0000, 9'h020};
    return {a ^ {b[15:0], b[31:16]} ^ {rm, 26'h0, op}, b[8:0] & 9'h063};
  endfunction

  function automatic logic [3:0] acc_bits(input logic [8:0] f);
    return {f[6], f[0], f[1], f[5]};
  endfunction

  // Behavioural FPU pipeline, frozen while stalled
  logic [40:0] fpu_pipe [LAT];
  always @(posedge Clk_CI or posedge Rst_RI) begin
    if (Rst_RI) begin
      for (int i = 0; i < LAT; i++) fpu_pipe[i] <= '0;
    end else if (!FpuStall_SO) begin
      fpu_pipe[0] <= FpuEnable_SO ? fpu_calc(FpuOpA_DO, FpuOpB_DO, FpuRM_SO, FpuOP_SO) : 41'h0;
      for (int i = 1; i < LAT; i++) fpu_pipe[i] <= fpu_pipe[i-1];
    end
  end
  assign FpuResult_DI = fpu_pipe[LAT-1][40:9];
  assign FpuFlags_SI  = fpu_pipe[LAT-1][8:0];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // One clock: drive inputs at the falling edge, score handshakes that the next rising edge completes
  task automatic step();
    op_t         e;
    logic [40:0] r;
    @(negedge Clk_CI);
    cyc++;
    RespReady_SI = ready_rand ? 1'($urandom_range(1)) : ready_fixed;
    FlagsClr_SI  = clr_req;
    if (pend.size() > 0 && (!gap_mode || $urandom_range(3) != 0)) begin
      ReqValid_SI = 1'b1;
      ReqOpA_DI = pend[0].a;  ReqOpB_DI = pend[0].b;
      ReqRM_SI  = pend[0].rm; ReqOP_SI  = pend[0].op; ReqTag_DI = pend[0].tag;
    end else begin
      ReqValid_SI = 1'b0;
      ReqOpA_DI = $urandom; ReqOpB_DI = $urandom; ReqTag_DI = TAG_W'($urandom);
    end
    if (RespValid_SO && RespReady_SI) begin
      chk("resp_pending", 64'(expq.size() != 0), 64'd1);
      if (expq.size() != 0) begin
        e = expq.pop_front();
        r = fpu_calc(e.a, e.b, e.rm, e.op);
        acc_model = acc_model | acc_bits(r[8:0]);
        chk("resp_result", 64'(RespResult_DO), 64'(r[40:9]));
        chk("resp_flags", 64'(RespFlags_SO), 64'(r[8:0]));
        chk("resp_tag", 64'(RespTag_DO), 64'(e.tag));
        chk("flags_acc", 64'(FlagsAcc_SO), 64'(acc_model));
        lat_log.push_back(cyc - e.acc_cyc - 1);
      end
      resp_log.push_back(cyc);
      n_resp++;
    end
    if (ReqValid_SI && ReqReady_SO) begin
      e = pend.pop_front();
      e.acc_cyc = cyc;
      expq.push_back(e);
    end
    if (clr_req) begin
      acc_model = '0;
      clr_req   = 1'b0;
    end
  endtask

  task automatic check_reset(input string p);
    chk({p, "_resp_valid"}, 64'(RespValid_SO), 64'd0);
    chk({p, "_resp_result"}, 64'(RespResult_DO), 64'd0);
    chk({p, "_resp_flags"}, 64'(RespFlags_SO), 64'd0);
    chk({p, "_resp_tag"}, 64'(RespTag_DO), 64'd0);
    chk({p, "_flags_acc"}, 64'(FlagsAcc_SO), 64'd0);
    chk({p, "_enable"}, 64'(FpuEnable_SO), 64'd0);
    chk({p, "_stall"}, 64'(FpuStall_SO), 64'd0);
    chk({p, "_req_ready"}, 64'(ReqReady_SO), 64'd1);
    chk({p, "_fpu_opa"}, 64'(FpuOpA_DO), 64'd0);
    chk({p, "_fpu_opb"}, 64'(FpuOpB_DO), 64'd0);
    chk({p, "_fpu_rm_op"}, 64'({FpuRM_SO, FpuOP_SO}), 64'd0);
  endtask

  // Push one isolated op and check latency and payload; optionally clear flags on the load edge
  task automatic run_single(input vec_t v, input bit clr_at_load, input string nm);
    op_t o;
    int  k;
    o.a = v.a; o.b = v.b; o.rm = 2'b00; o.op = v.op; o.tag = v.tag; o.acc_cyc = 0;
    pend.push_back(o);
    step();
    chk({nm, "_accepted"}, 64'(expq.size()), 64'd1);
    k = 0;
    while (!RespValid_SO && k < 20) begin
      if (clr_at_load && k == 2) clr_req = 1'b1;
      step();
      k++;
    end
    chk({nm, "_latency_edges"}, 64'(k - 1), 64'(LAT + 1));
    chk({nm, "_result"}, 64'(RespResult_DO), 64'(v.res));
    chk({nm, "_flags"}, 64'(RespFlags_SO), 64'(v.fl));
    chk({nm, "_tag"}, 64'(RespTag_DO), 64'(v.tag));
    chk({nm, "_acc"}, 64'(FlagsAcc_SO), 64'(v.acc));
    step();
  endtask

  task automatic fill_stalled(input logic [31:0] b_or);
    op_t o;
    ready_fixed = 1'b0;
    for (int i = 0; i < 5; i++) begin
      o.a = $urandom; o.b = $urandom | b_or; o.rm = 2'($urandom); o.op = 4'($urandom);
      o.tag = TAG_W'(i); o.acc_cyc = 0;
      pend.push_back(o);
    end
    repeat (8) step();
  endtask

  initial begin
    vec_t vt [4];
    vec_t vx;
    int   guard;
    int   base;
    op_t  o;

    vt[0] = '{a: 32'h3F80_0000, b: 32'h4000_0000, op: 4'h0, tag: 4'h3, clr_before: 0,
              res: 32'h4040_0000, fl: 9'h020, acc: 4'b0001};
    vt[1] = '{a: 32'h0000_1111, b: 32'h0000_0040, op: 4'h2, tag: 4'h5, clr_before: 1,
              res: 32'h0040_1113, fl: 9'h040, acc: 4'b1000};
    vt[2] = '{a: 32'h0000_0000, b: 32'h0000_0001, op: 4'h0, tag: 4'h6, clr_before: 0,
              res: 32'h0001_0000, fl: 9'h001, acc: 4'b1100};
    vt[3] = '{a: 32'hFFFF_FFFF, b: 32'h0000_0063, op: 4'hF, tag: 4'hF, clr_before: 0,
              res: 32'hFF9C_FFF0, fl: 9'h063, acc: 4'b1111};

    // Power-on reset
    #1 Rst_RI = 1'b1;
    #2 check_reset("por");
    @(posedge Clk_CI); @(posedge Clk_CI);
    #2 Rst_RI = 1'b0;

    // Directed vector table: isolated ops, flag accumulation
    ready_fixed = 1'b1;
    foreach (vt[i]) begin
      if (vt[i].clr_before) begin
        clr_req = 1'b1;
        step();
        step();
        chk("acc_idle_clear", 64'(FlagsAcc_SO), 64'd0);
      end
      run_single(vt[i], 1'b0, $sformatf("vec%0d", i));
    end

    // Clear on the same edge as a load keeps exactly the new flags
    vx = '{a: 32'h0, b: 32'h0000_0002, op: 4'h0, tag: 4'h9, clr_before: 0,
           res: 32'h0002_0000, fl: 9'h002, acc: 4'b0010};
    run_single(vx, 1'b1, "clr_with_load");

    // Back-to-back: eight ops, one per cycle, one response per cycle
    resp_log.delete(); lat_log.delete();
    for (int i = 0; i < 8; i++) begin
      o.a = $urandom; o.b = $urandom; o.rm = 2'($urandom); o.op = 4'($urandom);
      o.tag = TAG_W'(i); o.acc_cyc = 0;
      pend.push_back(o);
    end
    repeat (8) step();
    chk("b2b_all_accepted", 64'(pend.size()), 64'd0);
    guard = 0;
    while (expq.size() > 0 && guard < 20) begin step(); guard++; end
    chk("b2b_resp_count", 64'(resp_log.size()), 64'd8);
    for (int i = 1; i < resp_log.size(); i++)
      chk($sformatf("b2b_consecutive%0d", i), 64'(resp_log[i] - resp_log[0]), 64'(i));
    foreach (lat_log[i])
      chk($sformatf("b2b_latency%0d", i), 64'(lat_log[i]), 64'(LAT + 1));

    // Backpressure: response stuck, pipeline freezes, FIFO fills
    resp_log.delete();
    fill_stalled(32'h0);
    chk("bp_stall", 64'(FpuStall_SO), 64'd1);
    chk("bp_enable", 64'(FpuEnable_SO), 64'd0);
    chk("bp_req_ready", 64'(ReqReady_SO), 64'd0);
    chk("bp_resp_valid", 64'(RespValid_SO), 64'd1);
    chk("bp_resp_tag", 64'(RespTag_DO), 64'd0);
    chk("bp_all_accepted", 64'(expq.size()), 64'd5);
    step();
    chk("bp_tag_held", 64'(RespTag_DO), 64'd0);
    ready_fixed = 1'b1;
    guard = 0;
    while (expq.size() > 0 && guard < 30) begin step(); guard++; end
    repeat (5) step();
    chk("bp_resp_count", 64'(resp_log.size()), 64'd5);

    // Reset with two ops queued and two in flight
    fill_stalled(32'h41);
    chk("rst_setup_stall", 64'(FpuStall_SO), 64'd1);
    chk("rst_setup_queued", 64'(expq.size()), 64'd5);
    #2 Rst_RI = 1'b1;
    #1 check_reset("midflight");
    expq.delete(); pend.delete(); acc_model = '0;
    @(posedge Clk_CI); @(posedge Clk_CI);
    #2 Rst_RI = 1'b0;
    ready_fixed = 1'b1;
    base = n_resp;
    repeat (10) step();
    chk("rst_no_stale", 64'(n_resp - base), 64'd0);
    vx = '{a: 32'h1111_0000, b: 32'h0000_0020, op: 4'h3, tag: 4'h7, clr_before: 0,
           res: 32'h1131_0003, fl: 9'h020, acc: 4'b0001};
    run_single(vx, 1'b0, "post_reset");

    // Randomized traffic against the scoreboard
    base = n_resp;
    for (int i = 0; i < 300; i++) begin
      o.a = $urandom; o.b = $urandom; o.rm = 2'($urandom); o.op = 4'($urandom);
      o.tag = TAG_W'(i); o.acc_cyc = 0;
      pend.push_back(o);
    end
    ready_rand = 1; gap_mode = 1;
    guard = 0;
    while ((pend.size() > 0 || expq.size() > 0) && guard < 5000) begin step(); guard++; end
    ready_rand = 0; gap_mode = 0; ready_fixed = 1'b1;
    chk("rand_drained", 64'(pend.size() + expq.size()), 64'd0);
    chk("rand_resp_count", 64'(n_resp - base), 64'd300);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached with %0d checks done", n_checks);
    $fatal(1, "time limit");
  end

endmodule
